wb_lsu_ctrl: RTL and testbench
==============================

WB_LSU_CTRL -- requirements
Module: wb_lsu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum bus wait cycles before abort; range 2..65535.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid_i  in  1  CPU load/store request valid.
REQ-006 req_ready_o  out  1  request accepted when req_valid_i & req_ready_o.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr_i  in  32  byte address.
REQ-011 req_wdata_i  in  32  store data, right-aligned.
REQ-012 rsp_valid_o  out  1  one-cycle response pulse.
REQ-013 rsp_rdata_o  out  32  load result, extended; 0 for stores and errors.
REQ-014 rsp_err_o  out  2  00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout.
REQ-015 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls.
REQ-016 wb_adr_o  out  30  word address (req_addr_i[31:2]).
REQ-017 wb_sel_o  out  4  byte-lane enables.
REQ-018 wb_dat_o  out  32  lane-replicated store data.
REQ-019 wb_dat_i  in  32; wb_ack_i  in  1; wb_err_i  in  1  slave response.

Function
REQ-020 SHALL implement states IDLE, BUS, RESP; req_ready_o = 1 in IDLE only (combinational from state).
REQ-021 On acceptance, SHALL register we, size, unsigned, addr, wdata; illegal size or misalignment (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err 01, no bus cycle; else -> BUS.
REQ-022 In BUS, wb_cyc_o = wb_stb_o = 1, wb_we_o/adr/sel/dat_o stable from registered request; all four 0 outside BUS.
REQ-023 wb_sel_o: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111.
REQ-024 wb_dat_o: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-025 In BUS, wb_err_i = 1 -> RESP err 10 (err wins over simultaneous ack); else wb_ack_i = 1 -> RESP err 00, latching load data in the same edge.
REQ-026 Load data: select lane by addr/size, sign- or zero-extend to 32 bits per req_unsigned_i.
REQ-027 Timeout counter cleared on entering BUS, increments each BUS cycle without ack/err; at count TIMEOUT_CYCLES-1 without ack/err -> RESP err 11, bus deasserted next cycle.
REQ-028 RESP lasts exactly one cycle with rsp_valid_o = 1, then IDLE; rsp_* held at last values otherwise but rsp_valid_o = 0.
REQ-029 Latency: accept at edge N, BUS during cycle N+1; zero-wait ack at N+1 -> rsp_valid_o in cycle N+2; maximum throughput one request per 3 cycles.
REQ-030 wb_ack_i/wb_err_i outside BUS SHALL be ignored.

Reset
REQ-031 rst_n_i low SHALL immediately force state IDLE, counter 0, wb_cyc_o/stb_o/we_o 0, wb_sel_o 0, wb_adr_o 0, wb_dat_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 00; req_ready_o = 1.
REQ-032 Reset mid-BUS SHALL abort the cycle with no response; first request after release is serviced normally.

Structure
REQ-033 Size codes, error codes and state encoding SHALL live in shared package lsu_pkg.
REQ-034 Lane steering (REQ-023/024/026) SHALL be combinational sub-module wb_lane_align; FSM and counter in wb_lsu_ctrl.

Verification
REQ-035 Load byte addr 0x103, unsigned=0, slave returns 0x80xx_xxxx with ack same cycle -> sel 1000, rsp_rdata 0xFFFF_FF80, err 00, rsp_valid 2 cycles after accept.
REQ-036 Store half addr 0x202, wdata 0x0000_BEEF, ack after 3 waits -> wb_we 1, sel 1100, dat_o 0xBEEF_BEEF, rsp err 00, rdata 0.
REQ-037 Load word addr 0x0006 -> no wb_cyc_o assertion, rsp err 01 in cycle after accept; size 11 likewise.
REQ-038 TIMEOUT_CYCLES=4, slave never responds -> wb_cyc_o high exactly 4 cycles, rsp err 11; simultaneous ack+err -> err 10.
REQ-039 rst_n_i low during BUS -> wb_cyc_o 0 asynchronously, no rsp_valid_o; subsequent word load 0x400 completes with err 00.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the Wishbone load/store unit: access sizes, response
// error codes, controller states and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeIllegal = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ErrNone    = 2'b00,
        ErrAlign   = 2'b01,
        ErrBus     = 2'b10,
        ErrTimeout = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01,
        StResp = 2'b10
    } lsu_state_e;

    // True when the request must be rejected without touching the bus.
    function automatic logic req_illegal(lsu_size_e size, logic [1:0] addr_lo);
        logic bad;
        unique case (size)
            SizeByte: bad = 1'b0;
            SizeHalf: bad = addr_lo[0];
            SizeWord: bad = (addr_lo != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational byte-lane steering: store lane enables and replicated write
// data, plus extraction and extension of load data from the bus word.
module wb_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  lsu_size_e         size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              unsigned_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   bus_rdata_i,
    output logic [3:0]        sel_o,
    output logic [XLEN-1:0]   bus_wdata_o,
    output logic [XLEN-1:0]   load_data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = bus_rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = bus_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Lane enables, replicated store data and extended load data per access size
    always_comb begin
        sel_o       = 4'b0000;
        bus_wdata_o = '0;
        load_data_o = '0;
        unique case (size_i)
            SizeByte: begin
                sel_o       = 4'b0001 << addr_lo_i;
                bus_wdata_o = {4{wdata_i[7:0]}};
                load_data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
            end
            SizeHalf: begin
                sel_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                bus_wdata_o = {2{wdata_i[15:0]}};
                load_data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
            end
            SizeWord: begin
                sel_o       = 4'b1111;
                bus_wdata_o = wdata_i;
                load_data_o = bus_rdata_i;
            end
            default: begin
                sel_o       = 4'b0000;
                bus_wdata_o = '0;
                load_data_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/wb_lsu_ctrl.sv
// Load/store controller: accepts one CPU request at a time, runs a single
// Wishbone classic cycle with a timeout, and returns a one-cycle response.
module wb_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic [1:0]        rsp_err_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [XLEN-3:0]   wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [XLEN-1:0]   wb_dat_o,
    input  logic [XLEN-1:0]   wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic            we_q, uns_q;
    lsu_size_e       size_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [15:0]     cnt_q, cnt_d;
    lsu_err_e        rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

    logic            accept, illegal, in_bus, timeout;
    logic [3:0]      sel;
    logic [XLEN-1:0] bus_wdata, load_data;

    assign accept  = req_valid_i & (state_q == StIdle);
    assign illegal = req_illegal(lsu_size_e'(req_size_i), req_addr_i[1:0]);
    assign in_bus  = (state_q == StBus);
    assign timeout = (cnt_q == CntLast);

    wb_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .size_i      (size_q),
        .addr_lo_i   (addr_q[1:0]),
        .unsigned_i  (uns_q),
        .wdata_i     (wdata_q),
        .bus_rdata_i (wb_dat_i),
        .sel_o       (sel),
        .bus_wdata_o (bus_wdata),
        .load_data_o (load_data)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bus err and ack take priority over timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = illegal ? StResp : StBus;
                end
            end
            StBus: begin
                if (wb_err_i || wb_ack_i || timeout) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus and handshake outputs, all forced low outside the bus phase
    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StResp);
        wb_cyc_o    = in_bus;
        wb_stb_o    = in_bus;
        wb_we_o     = in_bus & we_q;
        wb_adr_o    = in_bus ? addr_q[XLEN-1:2] : '0;
        wb_sel_o    = in_bus ? sel : 4'b0000;
        wb_dat_o    = in_bus ? bus_wdata : '0;
    end

    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // Timeout counter and response next-state values
    always_comb begin
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            cnt_d = '0;
            if (illegal) begin
                rsp_err_d   = ErrAlign;
                rsp_rdata_d = '0;
            end
        end else if (in_bus) begin
            if (wb_err_i) begin
                rsp_err_d   = ErrBus;
                rsp_rdata_d = '0;
            end else if (wb_ack_i) begin
                rsp_err_d   = ErrNone;
                rsp_rdata_d = we_q ? '0 : load_data;
            end else if (timeout) begin
                rsp_err_d   = ErrTimeout;
                rsp_rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Request capture, counter and response registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SizeByte;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_err_q   <= ErrNone;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                size_q  <= lsu_size_e'(req_size_i);
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_wb_lsu_ctrl.sv
// Bench for wb_lsu_ctrl: directed scenarios plus randomized requests against
// an arithmetic reference model of lane selection, extension and timing.
module tb_wb_lsu_ctrl;

    localparam int unsigned T = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int errors = 0;
    int checks = 0;

    wb_lsu_ctrl #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_adr_o       (wb_adr_o),
        .wb_sel_o       (wb_sel_o),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_err_i       (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_illegal(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] load_model(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] dat);
        int          sh;
        logic [31:0] v;
        if (size == 2'd0) begin
            sh = 8 * int'(addr[1:0]);
            v  = (dat >> sh) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            sh = addr[1] ? 16 : 0;
            v  = (dat >> sh) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = dat;
        end
        return v;
    endfunction

    function automatic logic [3:0] sel_model(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] s;
        if (size == 2'd0)      s = 4'b0001 << addr[1:0];
        else if (size == 2'd1) s = addr[1] ? 4'b1100 : 4'b0011;
        else                   s = 4'b1111;
        return s;
    endfunction

    function automatic logic [31:0] dat_model(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0)      return 32'h0101_0101 * {24'd0, wd[7:0]};
        else if (size == 2'd1) return 32'h0001_0001 * {16'd0, wd[15:0]};
        return wd;
    endfunction

    // kind: 0 ack, 1 err, 2 ack+err together, 3 slave silent
    task automatic run_txn(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input int kind, input logic [31:0] rdat);
        int          bus_n = 0;
        int          lat = 0;
        int          exp_bus, exp_lat;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] got_rdata = '0;
        logic [1:0]  got_err = 2'b00;
        logic        bad;

        bad       = is_illegal(size, addr);
        exp_bus   = bad ? 0 : (kind == 3 ? int'(T) : waits + 1);
        exp_lat   = bad ? 1 : exp_bus + 1;
        exp_err   = bad ? 2'd1 : (kind == 3 ? 2'd3 : (kind == 0 ? 2'd0 : 2'd2));
        exp_rdata = (exp_err != 2'd0 || we) ? 32'd0 : load_model(size, uns, addr, rdat);

        @(negedge clk_i);
        chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk_i);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = $urandom;
            if (rsp_valid_o) begin
                lat       = i;
                got_rdata = rsp_rdata_o;
                got_err   = rsp_err_o;
                chk({tag, ".cyc_in_resp"}, 32'(wb_cyc_o), 32'd0);
                break;
            end
            if (wb_cyc_o) begin
                if (bus_n == 0) begin
                    chk({tag, ".stb"}, 32'(wb_stb_o), 32'd1);
                    chk({tag, ".we"}, 32'(wb_we_o), 32'(we));
                    chk({tag, ".adr"}, 32'(wb_adr_o), 32'(addr[31:2]));
                    chk({tag, ".sel"}, 32'(wb_sel_o), 32'(sel_model(size, addr)));
                    chk({tag, ".dat_o"}, wb_dat_o, dat_model(size, wdata));
                end
                if (bus_n == waits && kind != 3) begin
                    wb_ack_i = (kind != 1);
                    wb_err_i = (kind != 0);
                    wb_dat_i = rdat;
                end
                bus_n++;
            end
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        chk({tag, ".bus_cycles"}, 32'(bus_n), 32'(exp_bus));
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".err"}, 32'(got_err), 32'(exp_err));
        chk({tag, ".rdata"}, got_rdata, exp_rdata);
        @(negedge clk_i);
        chk({tag, ".pulse_end"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, ".err_held"}, 32'(rsp_err_o), 32'(exp_err));
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;

        // Reset state
        #2;
        chk("rst.ready", 32'(req_ready_o), 32'd1);
        chk("rst.cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst.stb", 32'(wb_stb_o), 32'd0);
        chk("rst.we", 32'(wb_we_o), 32'd0);
        chk("rst.sel", 32'(wb_sel_o), 32'd0);
        chk("rst.adr", 32'(wb_adr_o), 32'd0);
        chk("rst.dat", wb_dat_o, 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        chk("rst.err", 32'(rsp_err_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        run_txn("lb_0x103", 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 0, 32'h8012_3456);
        run_txn("sh_0x202", 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 3, 0, 32'h1234_5678);
        run_txn("lw_misal", 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
        run_txn("size11", 1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h0);
        run_txn("lh_odd", 1'b0, 2'd1, 1'b1, 32'h0000_0011, 32'h0, 0, 0, 32'h0);
        run_txn("timeout", 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 0, 3, 32'h0);
        run_txn("ack_err", 1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'h0, 1, 2, 32'hDEAD_BEEF);
        run_txn("lhu_hi", 1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 2, 0, 32'h9ABC_1234);

        // Slave handshakes while idle must not produce a response
        @(negedge clk_i);
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ack.rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("idle_ack.ready", 32'(req_ready_o), 32'd1);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;

        // Reset in the middle of a bus cycle
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_size_i  = 2'd2;
        req_addr_i  = 32'h0000_0800;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("midrst.cyc_before", 32'(wb_cyc_o), 32'd1);
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("midrst.cyc", 32'(wb_cyc_o), 32'd0);
        chk("midrst.sel", 32'(wb_sel_o), 32'd0);
        chk("midrst.ready", 32'(req_ready_o), 32'd1);
        chk("midrst.rsp_valid", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("midrst.no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        run_txn("lw_0x400", 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 1, 0, 32'hCAFE_F00D);

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            run_txn("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
                    $urandom, $urandom_range(0, T - 1), $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
